pcw_dn_sink: RTL and testbench
==============================

Name: pcw_dn_sink

Overview:
- Receiving end of the boot-loader download stream (dn_go/dn_wr/dn_addr/dn_data plus execute_addr/execute_enable).
- Buffers incoming bytes in a small FIFO and writes them into CPU RAM through a req/ack memory port.
- Holds the Z80 while a load is in progress, then releases it with a start pulse and PC when the loader requests execution.
- Sits between the boot-loader sequencer and the pcw_core memory arbiter.

Parameters:
- ADDR_W, 16, width of download and memory byte address.
- FIFO_DEPTH, 4, entries of {addr,data}; power of two, ≥2.

Ports:
- clk_sys  in  1  system clock (32 MHz); all logic on rising edge.
- reset  in  1  synchronous, active-high.
- dn_go  in  1  download active (level).
- dn_wr  in  1  one-cycle byte strobe.
- dn_addr  in  ADDR_W  byte address.
- dn_data  in  8  byte data.
- dn_wait  out  1  backpressure to loader.
- execute_addr  in  ADDR_W  start PC.
- execute_enable  in  1  one-cycle execute request.
- mem_req  out  1  write request (level).
- mem_ack  in  1  one-cycle completion from arbiter.
- mem_addr  out  ADDR_W  write address.
- mem_dout  out  8  write data.
- mem_we  out  1  equals mem_req (write-only port).
- cpu_hold  out  1  holds CPU in wait/reset.
- cpu_start  out  1  one-cycle launch pulse.
- cpu_pc  out  ADDR_W  launch PC, valid with cpu_start.
- byte_count  out  ADDR_W+1  bytes committed to memory this load.
- overflow  out  1  sticky: strobe dropped while FIFO full.

Behaviour:
- Reset (sync): state IDLE; FIFO emptied; all outputs 0; exec_pending cleared. A reset during an active mem_req drops it the same cycle. The arbiter tolerates an un-acked request being withdrawn.
- States: IDLE, LOAD, DRAIN, LAUNCH.
- IDLE:
  - cpu_hold=0; dn_wr ignored.
  - dn_go rising edge (registered compare) → LOAD. On entry: byte_count=0, overflow=0, cpu_hold=1 from the next cycle.
- LOAD:
  - dn_wr pushes {dn_addr,dn_data}.
  - dn_go falling edge → DRAIN.
- DRAIN:
  - Pushes still accepted.
  - dn_go rising edge → LOAD; FIFO, byte_count and hold are kept.
  - FIFO empty and mem_req=0: exec_pending → LAUNCH; otherwise → IDLE, releasing hold.
- LAUNCH: one cycle. cpu_start=1, cpu_pc=exec_pc, cpu_hold=1. Next cycle → IDLE; cpu_hold=0.
- execute_enable:
  - In LOAD or DRAIN: sets exec_pending and latches exec_pc=execute_addr. The last pulse wins.
  - It may coincide with the dn_go fall; both take effect.
  - In IDLE: ignored.
- FIFO:
  - Count width log2(FIFO_DEPTH)+1.
  - dn_wait registered: 1 when count ≥ FIFO_DEPTH-1 after this cycle's push/pop.
  - Push with count==FIFO_DEPTH and no pop the same cycle: byte dropped, overflow←1.
  - Simultaneous push and pop: count unchanged, no overflow.
- Memory port:
  - When mem_req=0 and FIFO non-empty, mem_req←1 next cycle, with mem_addr/mem_dout loaded from the head.
  - Held stable until a cycle with mem_ack=1. That cycle: pop, byte_count+1, and mem_req←0 on the next edge.
  - Re-request at the earliest one cycle after dropping, so back-to-back writes take 2 cycles plus ack latency.
  - mem_ack with mem_req=0 is ignored.
  - Minimum latency: dn_wr at cycle t → mem_req high at t+2.
- byte_count saturates at all-ones. Address is not checked for wrap; mem_addr is passed through verbatim (0xFFFF is legal).

Decomposition:
- Package pcw_dn_pkg: state enum (IDLE, LOAD, DRAIN, LAUNCH); typedef dn_entry_t {addr[ADDR_W], data[8]}.
- Sub-module pcw_dn_fifo: synchronous FIFO with push, pop, full, empty, count and the dn_wait threshold output.
- FSM and memory handshake live in the top.

Test Plan:
- Reset: all outputs 0, state IDLE. dn_wr=1 with dn_addr=0x0010 in IDLE → no mem_req, byte_count=0.
- Basic load: dn_go=1; 276 bytes (0x0000–0x0113, data=addr[7:0]) strobed every other cycle; mem_ack 1 cycle after each req. Then dn_go=0 with execute_enable and execute_addr=0x0000 in the same cycle → 276 writes in order, byte_count=276, one cpu_start with cpu_pc=0x0000, cpu_hold low 1 cycle after cpu_start.
- Backpressure: mem_ack delayed 10 cycles, dn_wr every cycle while dn_wait=0 → dn_wait asserts at count 3, no overflow, all bytes written in order.
- Overflow: FIFO_DEPTH=4, no acks, 6 strobes ignoring dn_wait → overflow=1, exactly 4 entries written after acks resume.
- No execute: load of 8 bytes, dn_go falls, no execute_enable → returns to IDLE, cpu_hold=0, cpu_start never pulses.
- Reset mid-load: reset asserted while mem_req=1 and FIFO holds 2 entries → mem_req=0 next cycle, FIFO empty, no further writes after reset deasserts.

Source files
------------

// File: rtl/pcw_dn_pkg.sv
// Shared types for the download sink: controller states and the buffered byte entry.
package pcw_dn_pkg;

  localparam int ADDR_W         = 16;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    LAUNCH
  } dn_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } dn_entry_t;

endpackage

// File: rtl/pcw_dn_sink_if.sv
// Download stream, CPU RAM write port and CPU launch controls of the download sink.
interface pcw_dn_sink_if;
  import pcw_dn_pkg::*;

  logic              dn_go;
  logic              dn_wr;
  logic [ADDR_W-1:0] dn_addr;
  logic [7:0]        dn_data;
  logic              dn_wait;
  logic [ADDR_W-1:0] execute_addr;
  logic              execute_enable;
  logic              mem_req;
  logic              mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_dout;
  logic              mem_we;
  logic              cpu_hold;
  logic              cpu_start;
  logic [ADDR_W-1:0] cpu_pc;
  logic [ADDR_W:0]   byte_count;
  logic              overflow;

  modport master (
    output dn_go, dn_wr, dn_addr, dn_data, execute_addr, execute_enable, mem_ack,
    input  dn_wait, mem_req, mem_addr, mem_dout, mem_we, cpu_hold, cpu_start, cpu_pc,
           byte_count, overflow
  );

  modport slave (
    input  dn_go, dn_wr, dn_addr, dn_data, execute_addr, execute_enable, mem_ack,
    output dn_wait, mem_req, mem_addr, mem_dout, mem_we, cpu_hold, cpu_start, cpu_pc,
           byte_count, overflow
  );

endinterface

// File: rtl/pcw_dn_fifo.sv
// Synchronous {addr,data} FIFO; push is dropped only when full with no pop the same cycle.
// dn_wait is registered and asserts once occupancy after this cycle reaches DEPTH-1.
module pcw_dn_fifo
  import pcw_dn_pkg::*;
#(
  parameter int DEPTH = 4
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  dn_entry_t              din,
  output dn_entry_t              head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   dn_wait
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  dn_entry_t     mem_q [DEPTH];
  dn_entry_t     mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          dn_wait_q, dn_wait_d;
  logic          push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign dn_wait = dn_wait_q;

  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end
    dn_wait_d = (count_d >= CW'(DEPTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dn_wait_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dn_wait_q <= dn_wait_d;
    end
    // Storage needs no reset: the pointers and count define what is valid.
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pcw_dn_sink.sv
// Boot-loader download sink: buffers bytes, writes them to CPU RAM over req/ack, holds and launches the CPU.
// dn_wr to mem_req is 2 cycles minimum; backpressure via registered dn_wait, strobes into a full FIFO are dropped.
module pcw_dn_sink
  import pcw_dn_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
)(
  input  logic         clk_sys,
  input  logic         reset,
  pcw_dn_sink_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  dn_state_t         state_q, state_d;
  logic              dn_go_q, dn_go_d;
  logic              exec_pending_q, exec_pending_d;
  logic [ADDR_W-1:0] exec_pc_q, exec_pc_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic [ADDR_W:0]   byte_count_q, byte_count_d;
  logic              overflow_q, overflow_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              cpu_start_q, cpu_start_d;
  logic [ADDR_W-1:0] cpu_pc_q, cpu_pc_d;

  dn_entry_t         fifo_din, fifo_head;
  logic              fifo_push, fifo_pop, fifo_empty, fifo_full, fifo_wait;
  logic [CW-1:0]     fifo_count;
  logic              go_rise, go_fall, accepting, exec_now;
  logic [ADDR_W-1:0] pc_now;

  assign fifo_din = {bus.dn_addr, bus.dn_data};

  pcw_dn_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk_sys),
    .rst     (reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (fifo_din),
    .head    (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count),
    .dn_wait (fifo_wait)
  );

  always_comb begin
    dn_go_d   = bus.dn_go;
    go_rise   = bus.dn_go && !dn_go_q;
    go_fall   = !bus.dn_go && dn_go_q;
    accepting = (state_q == LOAD) || (state_q == DRAIN);
    fifo_push = accepting && bus.dn_wr;
    fifo_pop  = mem_req_q && bus.mem_ack;
    exec_now  = exec_pending_q || (accepting && bus.execute_enable);
    pc_now    = (accepting && bus.execute_enable) ? bus.execute_addr : exec_pc_q;

    state_d        = state_q;
    exec_pending_d = exec_pending_q;
    exec_pc_d      = exec_pc_q;
    mem_req_d      = mem_req_q;
    mem_addr_d     = mem_addr_q;
    mem_dout_d     = mem_dout_q;
    byte_count_d   = byte_count_q;
    overflow_d     = overflow_q;
    cpu_hold_d     = cpu_hold_q;
    cpu_start_d    = 1'b0;
    cpu_pc_d       = cpu_pc_q;

    if (fifo_pop && (byte_count_q != '1)) begin
      byte_count_d = byte_count_q + 1'b1;
    end
    if (fifo_push && fifo_full && !fifo_pop) begin
      overflow_d = 1'b1;
    end

    // The request drops for one cycle after each ack, so the next head is loaded fresh.
    if (!mem_req_q && !fifo_empty) begin
      mem_req_d  = 1'b1;
      mem_addr_d = fifo_head.addr;
      mem_dout_d = fifo_head.data;
    end else if (fifo_pop) begin
      mem_req_d = 1'b0;
    end

    if (accepting && bus.execute_enable) begin
      exec_pending_d = 1'b1;
      exec_pc_d      = bus.execute_addr;
    end

    case (state_q)
      IDLE: begin
        if (go_rise) begin
          state_d      = LOAD;
          byte_count_d = '0;
          overflow_d   = 1'b0;
          cpu_hold_d   = 1'b1;
        end
      end
      LOAD: begin
        if (go_fall) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (go_rise) begin
          state_d = LOAD;
        end else if ((fifo_count == '0) && !fifo_push && !mem_req_q) begin
          exec_pending_d = 1'b0;
          if (exec_now) begin
            state_d     = LAUNCH;
            cpu_start_d = 1'b1;
            cpu_pc_d    = pc_now;
          end else begin
            state_d    = IDLE;
            cpu_hold_d = 1'b0;
          end
        end
      end
      LAUNCH: begin
        state_d    = IDLE;
        cpu_hold_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q        <= IDLE;
      dn_go_q        <= 1'b0;
      exec_pending_q <= 1'b0;
      exec_pc_q      <= '0;
      mem_req_q      <= 1'b0;
      mem_addr_q     <= '0;
      mem_dout_q     <= '0;
      byte_count_q   <= '0;
      overflow_q     <= 1'b0;
      cpu_hold_q     <= 1'b0;
      cpu_start_q    <= 1'b0;
      cpu_pc_q       <= '0;
    end else begin
      state_q        <= state_d;
      dn_go_q        <= dn_go_d;
      exec_pending_q <= exec_pending_d;
      exec_pc_q      <= exec_pc_d;
      mem_req_q      <= mem_req_d;
      mem_addr_q     <= mem_addr_d;
      mem_dout_q     <= mem_dout_d;
      byte_count_q   <= byte_count_d;
      overflow_q     <= overflow_d;
      cpu_hold_q     <= cpu_hold_d;
      cpu_start_q    <= cpu_start_d;
      cpu_pc_q       <= cpu_pc_d;
    end
  end

  // Reset withdraws an outstanding request in the same cycle; the arbiter tolerates it.
  assign bus.mem_req    = mem_req_q && !reset;
  assign bus.mem_we     = mem_req_q && !reset;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_dout   = mem_dout_q;
  assign bus.dn_wait    = fifo_wait;
  assign bus.byte_count = byte_count_q;
  assign bus.overflow   = overflow_q;
  assign bus.cpu_hold   = cpu_hold_q;
  assign bus.cpu_start  = cpu_start_q;
  assign bus.cpu_pc     = cpu_pc_q;

endmodule

// File: tb/tb_pcw_dn_sink.sv
// Randomized bench for pcw_dn_sink against a queue-based scoreboard of accepted bytes.
module tb_pcw_dn_sink;
  import pcw_dn_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;

  pcw_dn_sink_if bus();

  pcw_dn_sink #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_sys (clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  dn_entry_t   exp_q[$];
  logic        m_ovf, load_phase, prev_go, exp_exec, prev_start, ack_en, wait_seen;
  int          m_bytes, writes, starts, ack_cnt, ack_lat;
  logic [15:0] exp_pc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  // One clock cycle: drive the arbiter side, score this cycle, advance to the next negedge.
  task automatic step();
    logic      req, popped;
    int        occ;
    dn_entry_t e;
    req = bus.mem_req;
    if (req) begin
      if (ack_en && ack_cnt >= ack_lat) begin
        bus.mem_ack = 1'b1;
        ack_cnt     = 0;
      end else begin
        bus.mem_ack = 1'b0;
        ack_cnt++;
      end
    end else begin
      ack_cnt     = 0;
      bus.mem_ack = ($urandom_range(0, 3) == 0);
    end

    if (reset) begin
      exp_q.delete();
      m_ovf = 0; m_bytes = 0; load_phase = 0; prev_go = 0; exp_exec = 0; prev_start = 0;
    end else begin
      check_eq("dn_wait", bus.dn_wait, exp_q.size() >= DEPTH - 1);
      check_eq("overflow", bus.overflow, m_ovf);
      check_eq("byte_count", bus.byte_count, m_bytes);
      check_eq("mem_we", bus.mem_we, req);
      if (bus.dn_wait) wait_seen = 1;
      if (req) check_eq("req_has_data", exp_q.size() != 0, 1);
      if (prev_start) check_eq("hold_after_start", bus.cpu_hold, 0);
      if (bus.cpu_start) begin
        check_eq("start_expected", exp_exec, 1);
        check_eq("cpu_pc", bus.cpu_pc, exp_pc);
        check_eq("hold_at_start", bus.cpu_hold, 1);
        starts++;
        exp_exec = 0;
      end
      occ    = exp_q.size();
      popped = 0;
      if (req && bus.mem_ack) begin
        check_eq("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("mem_addr", bus.mem_addr, e.addr);
          check_eq("mem_dout", bus.mem_dout, e.data);
          popped = 1;
          m_bytes++;
          writes++;
        end
      end
      if (load_phase && bus.dn_wr) begin
        if (occ == DEPTH && !popped) m_ovf = 1;
        else exp_q.push_back({bus.dn_addr, bus.dn_data});
      end
      if (load_phase && bus.execute_enable) begin
        exp_exec = 1;
        exp_pc   = bus.execute_addr;
      end
      if (bus.dn_go && !prev_go) begin
        load_phase = 1; m_bytes = 0; m_ovf = 0;
      end
      if (!bus.dn_go && prev_go) load_phase = 0;
      prev_go    = bus.dn_go;
      prev_start = bus.cpu_start;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [15:0] a, input logic [7:0] d);
    bus.dn_wr   = 1'b1;
    bus.dn_addr = a;
    bus.dn_data = d;
    step();
    bus.dn_wr = 1'b0;
  endtask

  task automatic pulse_exec(input logic [15:0] a);
    bus.execute_enable = 1'b1;
    bus.execute_addr   = a;
    step();
    bus.execute_enable = 1'b0;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n = 0;
    while ((bus.cpu_hold || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check_eq(tag, (bus.cpu_hold == 1'b0) && (exp_q.size() == 0), 1);
    repeat (3) step();
  endtask

  initial begin
    int s0, w0, guard;
    logic [15:0] a1, a2;
    reset = 1'b1;
    bus.dn_go = 0; bus.dn_wr = 0; bus.dn_addr = 0; bus.dn_data = 0;
    bus.execute_addr = 0; bus.execute_enable = 0; bus.mem_ack = 0;
    ack_en = 1; ack_lat = 1; ack_cnt = 0; writes = 0; starts = 0; wait_seen = 0;
    m_ovf = 0; m_bytes = 0; load_phase = 0; prev_go = 0; exp_exec = 0; prev_start = 0; exp_pc = 0;
    @(negedge clk);
    step(); step();
    reset = 1'b0;

    // Reset state and strobes ignored while idle
    check_eq("rst_mem_req", bus.mem_req, 0);
    check_eq("rst_mem_addr", bus.mem_addr, 0);
    check_eq("rst_mem_dout", bus.mem_dout, 0);
    check_eq("rst_dn_wait", bus.dn_wait, 0);
    check_eq("rst_cpu_hold", bus.cpu_hold, 0);
    check_eq("rst_cpu_start", bus.cpu_start, 0);
    check_eq("rst_cpu_pc", bus.cpu_pc, 0);
    check_eq("rst_byte_count", bus.byte_count, 0);
    check_eq("rst_overflow", bus.overflow, 0);
    bus.dn_wr = 1; bus.dn_addr = 16'h0010; bus.dn_data = 8'h5a;
    repeat (4) step();
    bus.dn_wr = 0;
    check_eq("idle_no_req", bus.mem_req, 0);
    check_eq("idle_byte_count", bus.byte_count, 0);

    // Basic load: 276 bytes every other cycle, execute at the dn_go fall
    s0 = starts; w0 = writes;
    bus.dn_go = 1; step();
    check_eq("hold_in_load", bus.cpu_hold, 1);
    for (int i = 0; i < 276; i++) begin
      guard = 0;
      while (bus.dn_wait && guard < 200) begin step(); guard++; end
      push_byte(i[15:0], i[7:0]);
      step();
    end
    bus.dn_go = 0;
    pulse_exec(16'h0000);
    run_until_idle("basic_idle", 4000);
    check_eq("basic_bytes", bus.byte_count, 276);
    check_eq("basic_writes", writes - w0, 276);
    check_eq("basic_starts", starts - s0, 1);

    // Backpressure: slow acks, strobes every cycle while dn_wait is low
    ack_lat = 10; wait_seen = 0; s0 = starts; w0 = writes;
    bus.dn_go = 1; step();
    for (int i = 0; i < 20; i++) begin
      guard = 0;
      while (bus.dn_wait && guard < 200) begin step(); guard++; end
      push_byte(16'($urandom), 8'($urandom));
    end
    bus.dn_go = 0; step();
    run_until_idle("bp_idle", 2000);
    check_eq("bp_wait_seen", wait_seen, 1);
    check_eq("bp_overflow", bus.overflow, 0);
    check_eq("bp_writes", writes - w0, 20);
    check_eq("bp_no_start", starts - s0, 0);

    // Overflow: no acks, 6 strobes ignoring dn_wait; last execute pulse wins
    ack_en = 0; ack_lat = $urandom_range(0, 3); s0 = starts; w0 = writes;
    a1 = 16'($urandom); a2 = 16'($urandom);
    bus.dn_go = 1; step();
    for (int i = 0; i < 6; i++) push_byte(16'($urandom), 8'($urandom));
    step();
    check_eq("ovf_set", bus.overflow, 1);
    pulse_exec(a1);
    step();
    pulse_exec(a2);
    ack_en = 1;
    bus.dn_go = 0; step();
    run_until_idle("ovf_idle", 500);
    check_eq("ovf_writes", writes - w0, 4);
    check_eq("ovf_starts", starts - s0, 1);
    check_eq("ovf_pc", bus.cpu_pc, a2);

    // No execute: 8 bytes, minimum request latency, back to idle without a start
    ack_lat = $urandom_range(0, 3); s0 = starts; w0 = writes;
    bus.dn_go = 1; step();
    push_byte(16'hffff, 8'($urandom));
    check_eq("lat_t1", bus.mem_req, 0);
    step();
    check_eq("lat_t2", bus.mem_req, 1);
    for (int i = 1; i < 8; i++) push_byte(16'($urandom), 8'($urandom));
    bus.dn_go = 0; step();
    run_until_idle("noexec_idle", 500);
    check_eq("noexec_hold", bus.cpu_hold, 0);
    check_eq("noexec_starts", starts - s0, 0);
    check_eq("noexec_writes", writes - w0, 8);

    // Reset during an outstanding request with two entries buffered
    ack_en = 0; w0 = writes;
    bus.dn_go = 1; step();
    push_byte(16'($urandom), 8'($urandom));
    push_byte(16'($urandom), 8'($urandom));
    guard = 0;
    while (!bus.mem_req && guard < 20) begin step(); guard++; end
    check_eq("mid_req_seen", bus.mem_req, 1);
    reset = 1; bus.dn_go = 0;
    step();
    reset = 0;
    check_eq("mid_rst_req", bus.mem_req, 0);
    check_eq("mid_rst_wait", bus.dn_wait, 0);
    check_eq("mid_rst_hold", bus.cpu_hold, 0);
    check_eq("mid_rst_bytes", bus.byte_count, 0);
    ack_en = 1;
    repeat (20) step();
    check_eq("mid_no_writes", writes - w0, 0);
    check_eq("mid_req_quiet", bus.mem_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
